// File: rtl/pronoc_pkg.sv
// Shared NoC definitions: flit field layout, endpoint address encoding and
// the endpoint transmitter state encoding.
package pronoc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY
    } tx_state_e;

    // Flit layout, MSB first: {hdr, tail, vc_onehot[V], payload[Fpay]}
    function automatic int flit_pay_lsb();
        return 0;
    endfunction

    function automatic int flit_vc_lsb(input int fpay);
        return fpay;
    endfunction

    function automatic int flit_tail_bit(input int fpay, input int v);
        return fpay + v;
    endfunction

    function automatic int flit_hdr_bit(input int fpay, input int v);
        return fpay + v + 1;
    endfunction

    function automatic int endp_addr_w(input int k, input int l);
        return l * $clog2(k);
    endfunction

    // Base-k digits of pos, digit i placed at bits [i*kw +: kw].
    function automatic logic [31:0] fattree_endp_addr_encode(input int pos, input int k,
                                                             input int l, input int kw);
        logic [31:0] addr;
        int          rem;
        addr = '0;
        rem  = pos;
        for (int i = 0; i < l; i++) begin
            addr = addr | (32'(rem % k) << (i * kw));
            rem  = rem / k;
        end
        return addr;
    endfunction

endpackage

// File: rtl/fattree_endp_credit_cnt.sv
// Per-VC credit counter: starts full at B, saturates at B and flags an
// overflow when a credit arrives with nothing outstanding.
module fattree_endp_credit_cnt #(
    parameter int B = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic                dec,
    output logic [$clog2(B):0]  cnt,
    output logic                nonzero,
    output logic                overflow
);
    localparam int CW = $clog2(B) + 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        overflow = 1'b0;
        if (inc && !dec) begin
            if (cnt_q == CW'(B)) overflow = 1'b1;
            else                 cnt_d    = cnt_q + 1'b1;
        end else if (dec && !inc && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= CW'(B);
        else       cnt_q <= cnt_d;
    end

    assign cnt     = cnt_q;
    assign nonzero = (cnt_q != '0);

endmodule

// File: rtl/fattree_endp_pkt_tx.sv
// Endpoint packet transmitter: packs a request plus a body stream into
// head/body/tail flits for the fat-tree, gated by per-VC credits.
module fattree_endp_pkt_tx import pronoc_pkg::*; #(
    parameter int K           = 4,
    parameter int L           = 2,
    parameter int V           = 2,
    parameter int B           = 4,
    parameter int Fpay        = 32,
    parameter int MAX_PKT_LEN = 16,
    parameter int SRC_ID      = 0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic [$clog2(K**L)-1:0]               req_dst,
    input  logic [$clog2(MAX_PKT_LEN+1)-1:0]      req_len,
    input  logic [((V > 1) ? $clog2(V) : 1)-1:0]  req_vc,
    input  logic                                  data_valid,
    output logic                                  data_ready,
    input  logic [Fpay-1:0]                       data_in,
    output logic [2+V+Fpay-1:0]                   flit_out,
    output logic                                  flit_wr,
    input  logic [V-1:0]                          credit_in,
    output logic [V*($clog2(B)+1)-1:0]            credit_cnt,
    output logic                                  err_dst,
    output logic                                  err_credit
);
    localparam int KW       = $clog2(K);
    localparam int NE       = K ** L;
    localparam int EAW      = endp_addr_w(K, L);
    localparam int VW       = (V > 1) ? $clog2(V) : 1;
    localparam int LENW     = $clog2(MAX_PKT_LEN + 1);
    localparam int CW       = $clog2(B) + 1;
    localparam int FW       = 2 + V + Fpay;
    localparam int HDR_BIT  = flit_hdr_bit(Fpay, V);
    localparam int TAIL_BIT = flit_tail_bit(Fpay, V);
    localparam int VC_LSB   = flit_vc_lsb(Fpay);
    localparam int PAY_LSB  = flit_pay_lsb();
    localparam logic [EAW-1:0] SRC_ADDR = EAW'(fattree_endp_addr_encode(SRC_ID, K, L, KW));

    tx_state_e       state_q, state_d;
    logic [EAW-1:0]  dst_addr_q, dst_addr_d;
    logic [VW-1:0]   vc_q, vc_d;
    logic [LENW-1:0] len_q, len_d;
    logic [LENW-1:0] rem_q, rem_d;
    logic [FW-1:0]   flit_out_q, flit_out_d;
    logic            flit_wr_q, flit_wr_d;
    logic            err_dst_q, err_dst_d;
    logic            err_credit_q, err_credit_d;

    logic [CW-1:0]   cnt_vec [V];
    logic [V-1:0]    cnt_nz;
    logic [V-1:0]    ovf;
    logic [V-1:0]    dec_vec;
    logic [V-1:0]    vc_onehot;
    logic            send, hdr, tail;
    logic [Fpay-1:0] pay;

    assign vc_onehot = V'(1) << vc_q;

    always_comb begin
        state_d      = state_q;
        dst_addr_d   = dst_addr_q;
        vc_d         = vc_q;
        len_d        = len_q;
        rem_d        = rem_q;
        flit_out_d   = flit_out_q;
        flit_wr_d    = 1'b0;
        err_dst_d    = 1'b0;
        err_credit_d = err_credit_q | (|ovf);
        dec_vec      = '0;
        send         = 1'b0;
        hdr          = 1'b0;
        tail         = 1'b0;
        pay          = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (int'(req_dst) >= NE) begin
                        err_dst_d = 1'b1;
                    end else begin
                        dst_addr_d = EAW'(fattree_endp_addr_encode(int'(req_dst), K, L, KW));
                        vc_d       = req_vc;
                        len_d      = (req_len == '0) ? LENW'(1) : req_len;
                        state_d    = ST_HEAD;
                    end
                end
            end
            ST_HEAD: begin
                if (cnt_nz[vc_q]) begin
                    send = 1'b1;
                    hdr  = 1'b1;
                    tail = (len_q == LENW'(1));
                    pay  = Fpay'({len_q, SRC_ADDR, dst_addr_q});
                    if (tail) begin
                        state_d = ST_IDLE;
                    end else begin
                        rem_d   = len_q - 1'b1;
                        state_d = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (data_valid && cnt_nz[vc_q]) begin
                    send  = 1'b1;
                    tail  = (rem_q == LENW'(1));
                    pay   = data_in;
                    rem_d = rem_q - 1'b1;
                    if (tail) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Every send spends one credit of the active VC and lands on the
        // output one cycle later.
        if (send) begin
            flit_wr_d                  = 1'b1;
            flit_out_d                 = '0;
            flit_out_d[HDR_BIT]        = hdr;
            flit_out_d[TAIL_BIT]       = tail;
            flit_out_d[VC_LSB +: V]    = vc_onehot;
            flit_out_d[PAY_LSB +: Fpay] = pay;
            dec_vec                    = vc_onehot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            dst_addr_q   <= '0;
            vc_q         <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            flit_out_q   <= '0;
            flit_wr_q    <= 1'b0;
            err_dst_q    <= 1'b0;
            err_credit_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dst_addr_q   <= dst_addr_d;
            vc_q         <= vc_d;
            len_q        <= len_d;
            rem_q        <= rem_d;
            flit_out_q   <= flit_out_d;
            flit_wr_q    <= flit_wr_d;
            err_dst_q    <= err_dst_d;
            err_credit_q <= err_credit_d;
        end
    end

    for (genvar v = 0; v < V; v++) begin : g_cred
        fattree_endp_credit_cnt #(.B(B)) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .inc      (credit_in[v]),
            .dec      (dec_vec[v]),
            .cnt      (cnt_vec[v]),
            .nonzero  (cnt_nz[v]),
            .overflow (ovf[v])
        );
        assign credit_cnt[v*CW +: CW] = cnt_vec[v];
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign data_ready = (state_q == ST_BODY) && cnt_nz[vc_q];
    assign flit_out   = flit_out_q;
    assign flit_wr    = flit_wr_q;
    assign err_dst    = err_dst_q;
    assign err_credit = err_credit_q;

endmodule

// File: tb/tb_fattree_endp_pkt_tx.sv
// Bench for fattree_endp_pkt_tx: directed scenarios plus randomized packets,
// checked against a packet-level scoreboard and a credit accounting model.
module tb_fattree_endp_pkt_tx;
    localparam int K = 3, L = 2, V = 2, B = 4, FPAY = 32, MAXL = 16, SRC = 4;
    localparam int KW = 2, NE = 9, EAW = 4, VW = 1, LENW = 5, DW = 4, CW = 3;
    localparam int FW = 2 + V + FPAY;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid, req_ready;
    logic [DW-1:0]     req_dst;
    logic [LENW-1:0]   req_len;
    logic [VW-1:0]     req_vc;
    logic              data_valid, data_ready;
    logic [FPAY-1:0]   data_in;
    logic [FW-1:0]     flit_out;
    logic              flit_wr;
    logic [V-1:0]      credit_in;
    logic [V*CW-1:0]   credit_cnt;
    logic              err_dst, err_credit;

    fattree_endp_pkt_tx #(
        .K(K), .L(L), .V(V), .B(B), .Fpay(FPAY), .MAX_PKT_LEN(MAXL), .SRC_ID(SRC)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dst(req_dst), .req_len(req_len), .req_vc(req_vc),
        .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .flit_out(flit_out), .flit_wr(flit_wr),
        .credit_in(credit_in), .credit_cnt(credit_cnt),
        .err_dst(err_dst), .err_credit(err_credit)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [FW-1:0]   exp_q[$];
    logic [FPAY-1:0] data_q[$];
    int cred[V];
    bit err_model;
    int nflits = 0;
    int feed_budget;
    bit rnd_mode, auto_cred;
    int n0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [EAW-1:0] addr_of(input int x);
        logic [EAW-1:0] a;
        int p;
        a = '0;
        p = 1;
        for (int i = 0; i < L; i++) begin
            a[i*KW +: KW] = KW'((x / p) % K);
            p = p * K;
        end
        return a;
    endfunction

    function automatic logic [FW-1:0] head_flit(input int dst, input int len, input int vc);
        logic [FPAY-1:0] p;
        logic [V-1:0]    oh;
        p = '0;
        p[EAW-1:0]       = addr_of(dst);
        p[2*EAW-1:EAW]   = addr_of(SRC);
        p[2*EAW +: LENW] = LENW'(len);
        oh = V'(1) << vc;
        return {1'b1, (len == 1), oh, p};
    endfunction

    task automatic update_drive();
        if (data_q.size() > 0 && feed_budget > 0 && (!rnd_mode || $urandom_range(0, 3) != 0))
            data_valid = 1'b1;
        else
            data_valid = 1'b0;
        data_in = (data_q.size() > 0) ? data_q[0] : '0;
        if (auto_cred)
            for (int v = 0; v < V; v++)
                credit_in[v] = (cred[v] < B) && ($urandom_range(0, 1) == 1);
    endtask

    task automatic tick();
        logic [V-1:0]  cin, dec;
        logic [FW-1:0] e;
        bit hs_d, hs_r;
        hs_d = data_valid && data_ready;
        hs_r = req_valid && req_ready;
        cin  = credit_in;
        @(posedge clk);
        #1;
        if (hs_d) begin
            void'(data_q.pop_front());
            feed_budget--;
        end
        if (hs_r) req_valid = 1'b0;
        dec = '0;
        if (flit_wr) begin
            nflits++;
            if (exp_q.size() == 0) begin
                check("spurious_flit_wr", 64'(flit_wr), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("flit", 64'(flit_out), 64'(e));
                dec = e[FPAY +: V];
            end
        end
        for (int v = 0; v < V; v++) begin
            if (cin[v] && !dec[v]) begin
                if (cred[v] == B) err_model = 1'b1;
                else              cred[v]++;
            end else if (dec[v] && !cin[v]) begin
                cred[v]--;
            end
        end
        for (int v = 0; v < V; v++)
            check("credit_cnt", 64'(credit_cnt[v*CW +: CW]), 64'(cred[v]));
        check("err_credit", 64'(err_credit), 64'(err_model));
        update_drive();
    endtask

    task automatic issue(input int dst, input int len, input int vc);
        int le;
        logic [FPAY-1:0] d;
        logic [V-1:0] oh;
        le = (len == 0) ? 1 : len;
        oh = V'(1) << vc;
        req_dst   = DW'(dst);
        req_len   = LENW'(len);
        req_vc    = VW'(vc);
        req_valid = 1'b1;
        if (dst < NE) begin
            exp_q.push_back(head_flit(dst, le, vc));
            for (int i = 1; i < le; i++) begin
                d = $urandom;
                data_q.push_back(d);
                exp_q.push_back({1'b0, (i == le - 1), oh, d});
            end
        end
        update_drive();
        for (int t = 0; t < 400 && req_valid; t++) tick();
        if (req_valid) check("req_accept_timeout", 64'(req_valid), 64'(0));
        req_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        for (int t = 0; t < max_cyc && (exp_q.size() != 0 || !req_ready); t++) tick();
        check("drain_pending", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic restore();
        auto_cred = 1'b0;
        for (int t = 0; t < 4 * B; t++) begin
            for (int v = 0; v < V; v++) credit_in[v] = (cred[v] < B);
            if (credit_in == '0) break;
            tick();
        end
        credit_in = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_dst = '0; req_len = '0; req_vc = '0;
        data_valid = 1'b0; data_in = '0; credit_in = '0;
        for (int v = 0; v < V; v++) cred[v] = B;
        err_model = 1'b0; feed_budget = 1 << 30; rnd_mode = 1'b0; auto_cred = 1'b0;
        #1;
        check("rst_flit_wr", 64'(flit_wr), 64'(0));
        check("rst_flit_out", 64'(flit_out), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_data_ready", 64'(data_ready), 64'(0));
        check("rst_err_dst", 64'(err_dst), 64'(0));
        check("rst_err_credit", 64'(err_credit), 64'(0));
        check("rst_credit_cnt", 64'(credit_cnt), 64'(6'b100_100));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // single-flit packet, loopback-free address encoding
        issue(7, 1, 1);
        tick();
        check("t1_flit_wr", 64'(flit_wr), 64'(1));
        check("t1_hdr", 64'(flit_out[35]), 64'(1));
        check("t1_tail", 64'(flit_out[34]), 64'(1));
        check("t1_vc", 64'(flit_out[33:32]), 64'(2'b10));
        check("t1_dst", 64'(flit_out[3:0]), 64'(4'b1001));
        check("t1_src", 64'(flit_out[7:4]), 64'(4'b0101));
        check("t1_len", 64'(flit_out[12:8]), 64'(1));
        check("t1_cnt1", 64'(credit_cnt[5:3]), 64'(3));
        restore();

        // back-to-back head and bodies
        issue(5, 4, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_consecutive", 64'(flit_wr), 64'(1));
        end
        check("t2_tail", 64'(flit_out[34]), 64'(1));
        check("t2_cnt0", 64'(credit_cnt[2:0]), 64'(0));
        restore();

        // credit starvation
        n0 = nflits;
        issue(2, 6, 0);
        repeat (8) tick();
        check("t3_flits_before_stall", 64'(nflits - n0), 64'(4));
        check("t3_data_ready", 64'(data_ready), 64'(0));
        check("t3_flit_wr_stalled", 64'(flit_wr), 64'(0));
        credit_in = 2'b01;
        tick();
        credit_in = '0;
        check("t3_release_early", 64'(flit_wr), 64'(0));
        tick();
        check("t3_release", 64'(flit_wr), 64'(1));
        tick();
        check("t3_single_release", 64'(flit_wr), 64'(0));
        credit_in = 2'b01;
        tick();
        credit_in = '0;
        drain(20);
        restore();

        // simultaneous send and return, overflow on the idle VC
        issue(1, 1, 0);
        drain(10);
        issue(3, 3, 0);
        for (int t = 0; t < 10; t++) begin
            if (data_ready && credit_cnt[2:0] == 3'd2) break;
            tick();
        end
        credit_in = 2'b11;
        tick();
        credit_in = '0;
        check("t4_cnt0_hold", 64'(credit_cnt[2:0]), 64'(2));
        check("t4_cnt1_sat", 64'(credit_cnt[5:3]), 64'(4));
        check("t4_err_credit", 64'(err_credit), 64'(1));
        drain(20);
        restore();

        // out-of-range destination
        n0 = nflits;
        issue(9, 3, 0);
        check("t5_err_dst", 64'(err_dst), 64'(1));
        check("t5_no_flit", 64'(flit_wr), 64'(0));
        check("t5_req_ready", 64'(req_ready), 64'(1));
        tick();
        check("t5_err_dst_pulse", 64'(err_dst), 64'(0));
        check("t5_req_ready2", 64'(req_ready), 64'(1));
        tick();
        check("t5_flit_count", 64'(nflits - n0), 64'(0));

        // randomized packets with background credit returns
        rnd_mode = 1'b1;
        auto_cred = 1'b1;
        for (int p = 0; p < 12; p++)
            issue($urandom_range(0, NE - 1), $urandom_range(0, MAXL), $urandom_range(0, V - 1));
        drain(3000);
        rnd_mode = 1'b0;
        auto_cred = 1'b0;
        credit_in = '0;
        restore();

        // reset in the middle of a body
        n0 = nflits;
        feed_budget = 1;
        issue(8, 5, 0);
        repeat (6) tick();
        check("t6_flits_before_reset", 64'(nflits - n0), 64'(2));
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_flit_wr", 64'(flit_wr), 64'(0));
        check("t6_rst_credit_cnt", 64'(credit_cnt), 64'(6'b100_100));
        check("t6_rst_req_ready", 64'(req_ready), 64'(1));
        check("t6_rst_err_credit", 64'(err_credit), 64'(0));
        exp_q.delete();
        data_q.delete();
        for (int v = 0; v < V; v++) cred[v] = B;
        err_model = 1'b0;
        feed_budget = 1 << 30;
        data_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n0 = nflits;
        issue(6, 2, 1);
        drain(20);
        check("t6_post_reset_flits", 64'(nflits - n0), 64'(2));
        check("t6_post_reset_tail", 64'(flit_out[34]), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fattree_endp_pkt_tx.md
Name: fattree_endp_pkt_tx

Overview:
Endpoint-side packet transmitter for the fat-tree NoC. It turns a packet request (destination endpoint, length, VC) plus a body-payload stream into head/body/tail flits with credit-based flow control, and drives one endpoint input channel of the fat-tree. Destination and source IDs are encoded in the fat-tree base-K digit address format that leaf routers use for routing. There is one instance per endpoint.

Parameters:
K, 4, fat-tree radix; NE = K^L; Kw = clog2(K)
L, 2, number of tree levels; endpoint address EAw = L*Kw
V, 2, virtual channels; Vw = max(1, clog2(V))
B, 4, per-VC buffer depth at the router input, which is also the initial credit count
Fpay, 32, flit payload width; must be at least 2*EAw + LENw
MAX_PKT_LEN, 16, maximum flits per packet; LENw = clog2(MAX_PKT_LEN+1)
SRC_ID, 0, this endpoint's index, 0..NE-1

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  1  packet request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_dst  in  clog2(NE)  destination endpoint index
req_len  in  LENw  total flits including head; 0 is treated as 1
req_vc  in  Vw  VC index
data_valid  in  1  body payload valid
data_ready  out  1  body payload consumed when data_valid && data_ready
data_in  in  Fpay  body payload
flit_out  out  2+V+Fpay  {hdr, tail, vc_onehot[V], payload}
flit_wr  out  1  flit_out valid this cycle
credit_in  in  V  one credit return per VC bit per cycle
credit_cnt  out  V*(clog2(B)+1)  per-VC credit counters, VC0 in the LSBs
err_dst  out  1  one-cycle pulse: request had req_dst >= NE
err_credit  out  1  sticky: a credit was returned while the counter was already at B

Behaviour:
- Reset values: state IDLE, flit_wr=0, flit_out=0, req_ready=1, data_ready=0, err_dst=0, err_credit=0, every credit counter = B.
- Reset asserted mid-packet truncates the packet silently and restores all credits to B.
- Addressing: addr(x) is the base-K digits of x, with digit i at bits [i*Kw +: Kw].
  - Head payload = {zeros, len[LENw], addr(SRC_ID)[EAw], addr(req_dst)[EAw]}, with dst in the LSBs.
- FSM has three states: IDLE, HEAD, BODY.
  - IDLE: req_ready=1. On acceptance, latch dst, vc and len (0 becomes 1) and go to HEAD.
    - If req_dst >= NE: pulse err_dst next cycle, emit no flits, stay in IDLE.
  - HEAD: req_ready=0. When credit_cnt[vc] != 0, send the head flit with hdr=1 and tail=(len==1).
    - If len==1, go to IDLE; otherwise load remaining = len-1 and go to BODY.
  - BODY: data_ready = (credit_cnt[vc] != 0). Each handshake sends one flit with hdr=0 and payload=data_in, then decrements remaining.
    - When remaining==1, that flit carries tail=1 and the FSM returns to IDLE.
- Output timing: flit_out and flit_wr are registered. A flit appears exactly 1 cycle after its send decision.
  - vc_onehot = 1 << vc.
  - Minimum spacing between packets is 1 idle cycle (the IDLE→HEAD cycle).
- Credits are tracked per VC by a counter.
  - A send decrements the counter.
  - credit_in[v] increments it.
  - Both in the same cycle leave it unchanged.
  - The send decision uses the registered count, so a credit returned in the same cycle is usable from the next cycle.
  - The counter never goes below 0; sending at 0 cannot occur by construction.
  - An increment at B saturates and sets err_credit, which stays set until reset.
- Credits on VCs other than the active VC are still counted.
- Destination dst==SRC_ID is legal (loopback).

Decomposition:
- Shared package pronoc_pkg additions:
  - flit field offsets: HDR_BIT, TAIL_BIT, VC_LSB, PAY_LSB;
  - the endpoint address width function;
  - function fattree_endp_addr_encode(pos, K, L, Kw).
- Sub-module fattree_endp_credit_cnt (parameter B): one counter with inc, dec, cnt, nonzero and overflow outputs; instantiated V times.

Test Plan:
1. K=3, L=2, SRC_ID=4; request dst=7, len=1, vc=1. Expect one flit:
   - hdr=1, tail=1, vc_onehot=2'b10;
   - payload[3:0]=4'b1001, payload[7:4]=4'b0101 (src 4 = digits 1,1), len field=1;
   - credit_cnt[1] goes 4→3.
2. len=4, vc=0, data_valid held high, no credit returns. Expect:
   - a head flit then 3 body flits on consecutive cycles, the last with tail=1;
   - credit_cnt[0] ends at 0.
3. Credit starvation: issue a len=6 packet on VC0 with B=4. Expect:
   - flit_wr stops after 4 flits and data_ready=0;
   - a single credit_in[0] pulse releases exactly one flit, on the cycle after the next.
4. Simultaneous send and credit return on VC0 with credit_cnt=2. Expect the count stays 2.
   - Also pulse credit_in[1] while credit_cnt[1]=4: expect err_credit=1 and the count stays 4.
5. req_dst=9 with K=3, L=2 (NE=9). Expect err_dst pulses for 1 cycle, no flit_wr, req_ready=1 in the following cycle.
6. Assert reset during BODY with remaining=3. Expect:
   - flit_wr=0 and all credit_cnt=B immediately (asynchronous);
   - after release, a new len=2 request produces a correct head+tail sequence.
